uart_frame_ctrl: RTL

Frame-level controller downstream of the UART byte receiver (115200 baud, 50 MHz sys_clk).
- Consumes the receiver's byte strobe and data.
- Hunts for a two-byte header, collects command, length and payload, and verifies an 8-bit additive checksum.
- Presents each verified command to the control-board logic with a valid/ready handshake.
- Enforces an inter-byte timeout and reports framing errors.

---
 rtl/uart_frm_pkg.sv | 25 ++
 rtl/uart_frm_timer.sv | 29 ++
 rtl/uart_frame_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/uart_frm_pkg.sv
// uart_frm_pkg: shared definitions for the UART frame controller.
//   - state_e    : one-hot parser states
//   - HDR0/HDR1  : two-byte frame header (0x55, 0xAA)
//   - ERR_*      : err_code values reported with err_pulse
package uart_frm_pkg;

  typedef enum logic [6:0] {
    ST_HUNT1   = 7'b0000001,
    ST_HUNT2   = 7'b0000010,
    ST_CMD     = 7'b0000100,
    ST_LEN     = 7'b0001000,
    ST_PAYLOAD = 7'b0010000,
    ST_CHK     = 7'b0100000,
    ST_HOLD    = 7'b1000000
  } state_e;

  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hAA;

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_CHK     = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_DROP    = 2'd3;

endpackage

// File: rtl/uart_frm_timer.sv
// uart_frm_timer: inter-byte timeout counter.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : clear (byte event)
//   i_en         : count enable; counter is held at 0 while low
//   o_expire     : high in the cycle the count sits at TIMEOUT_CLKS-1
module uart_frm_timer #(
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  logic [TW-1:0] r_cnt;

  assign o_expire = i_en && (r_cnt == TW'(TIMEOUT_CLKS - 1));

  // Wrapping to 0 on expiry keeps the count in range even if the
  // parser were to stay enabled.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || !i_en || o_expire) r_cnt <= '0;
    else                                     r_cnt <= r_cnt + TW'(1);
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: frame parser behind a UART byte receiver.
// Hunts for 55 AA, collects CMD, LEN, payload and an additive checksum,
// then holds the verified command for a valid/ready consumer.
//   sys_clk, sys_rst   : clock, synchronous active-high reset
//   rx_done, rx_data   : byte strobe (rising edge counts) and data
//   cmd_valid/ready    : handshake for the held frame
//   cmd_code, cmd_len  : held command byte and payload length
//   pl_addr, pl_data   : combinational payload buffer read port
//   busy               : parser is inside a frame (CMD..CHK)
//   err_pulse/err_code : one-cycle error strobe and its cause
// Optional macro UART_FRM_STATS_EN adds saturating good_cnt/bad_cnt.
module uart_frame_ctrl
  import uart_frm_pkg::*;
#(
  parameter  int MAX_LEN      = 16,
  parameter  int TIMEOUT_CLKS = 50000,
  localparam int LEN_W        = $clog2(MAX_LEN + 1),
  localparam int AW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             rx_done,
  input  logic [7:0]       rx_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       cmd_code,
  output logic [LEN_W-1:0] cmd_len,
  input  logic [AW-1:0]    pl_addr,
  output logic [7:0]       pl_data,
  output logic             busy,
  output logic             err_pulse,
  output logic [1:0]       err_code
`ifdef UART_FRM_STATS_EN
  ,
  output logic [15:0]      good_cnt,
  output logic [15:0]      bad_cnt
`endif
);

  logic             r_rx_d, r_ev;
  logic [7:0]       r_byte;
  state_e           r_state;
  logic             r_cmd_valid;
  logic [7:0]       r_cmd_code, r_sum;
  logic [LEN_W-1:0] r_cmd_len;
  logic [AW-1:0]    r_idx;
  logic             r_err_pulse;
  logic [1:0]       r_err_code;
  // Sized to the full address space so any pl_addr reads a real entry.
  logic [7:0]       r_buf [1<<AW];
  logic             w_busy, w_expire, w_buf_we;

  // Edge detect plus one register stage: the FSM sees r_ev/r_byte,
  // giving two cycles from rx_done rising to the resulting state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rx_d <= 1'b0;
      r_ev   <= 1'b0;
      r_byte <= 8'h00;
    end else begin
      r_rx_d <= rx_done;
      r_ev   <= rx_done & ~r_rx_d;
      if (rx_done & ~r_rx_d) r_byte <= rx_data;
    end
  end

  assign w_busy   = r_state inside {ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHK};
  assign w_buf_we = r_ev && (r_state == ST_PAYLOAD);

  uart_frm_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
    .i_clk    (sys_clk),
    .i_rst    (sys_rst),
    .i_clr    (r_ev),
    .i_en     (w_busy),
    .o_expire (w_expire)
  );

  always_ff @(posedge sys_clk) begin
    if (w_buf_we) r_buf[r_idx] <= r_byte;
  end

`ifdef UART_FRM_STATS_EN
  logic [15:0] r_good_cnt, r_bad_cnt;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= ST_HUNT1;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= 8'h00;
      r_cmd_len   <= '0;
      r_idx       <= '0;
      r_sum       <= 8'h00;
      r_err_pulse <= 1'b0;
      r_err_code  <= ERR_TIMEOUT;
`ifdef UART_FRM_STATS_EN
      r_good_cnt  <= 16'h0000;
      r_bad_cnt   <= 16'h0000;
`endif
    end else begin
      r_err_pulse <= 1'b0;
`ifdef UART_FRM_STATS_EN
      if (r_err_pulse && r_bad_cnt != 16'hFFFF) r_bad_cnt <= r_bad_cnt + 16'd1;
`endif
      // A byte arriving on the expiry cycle wins over the timeout.
      if (w_expire && !r_ev) begin
        r_err_pulse <= 1'b1;
        r_err_code  <= ERR_TIMEOUT;
        r_state     <= ST_HUNT1;
      end else begin
        case (r_state)
          ST_HUNT1: if (r_ev && r_byte == HDR0) r_state <= ST_HUNT2;
          ST_HUNT2: if (r_ev) begin
            if (r_byte == HDR1)      r_state <= ST_CMD;
            else if (r_byte != HDR0) r_state <= ST_HUNT1;
          end
          ST_CMD: if (r_ev) begin
            r_cmd_code <= r_byte;
            r_sum      <= r_byte;
            r_state    <= ST_LEN;
          end
          ST_LEN: if (r_ev) begin
            if (r_byte > 8'(MAX_LEN)) begin
              r_err_pulse <= 1'b1;
              r_err_code  <= ERR_LEN;
              r_state     <= ST_HUNT1;
            end else begin
              r_cmd_len <= LEN_W'(r_byte);
              r_sum     <= r_sum + r_byte;
              r_idx     <= '0;
              r_state   <= (r_byte == 8'h00) ? ST_CHK : ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: if (r_ev) begin
            r_sum <= r_sum + r_byte;
            if (LEN_W'(r_idx) == r_cmd_len - LEN_W'(1)) r_state <= ST_CHK;
            else                                         r_idx   <= r_idx + AW'(1);
          end
          ST_CHK: if (r_ev) begin
            if (r_byte == r_sum) begin
              r_state     <= ST_HOLD;
              r_cmd_valid <= 1'b1;
`ifdef UART_FRM_STATS_EN
              if (r_good_cnt != 16'hFFFF) r_good_cnt <= r_good_cnt + 16'd1;
`endif
            end else begin
              r_err_pulse <= 1'b1;
              r_err_code  <= ERR_CHK;
              r_state     <= ST_HUNT1;
            end
          end
          ST_HOLD: begin
            // Drop and handshake are independent; both may happen at once.
            if (r_ev) begin
              r_err_pulse <= 1'b1;
              r_err_code  <= ERR_DROP;
            end
            if (r_cmd_valid && cmd_ready) begin
              r_cmd_valid <= 1'b0;
              r_state     <= ST_HUNT1;
            end
          end
          default: r_state <= ST_HUNT1;
        endcase
      end
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_code  = r_cmd_code;
  assign cmd_len   = r_cmd_len;
  assign pl_data   = r_buf[pl_addr];
  assign busy      = w_busy;
  assign err_pulse = r_err_pulse;
  assign err_code  = r_err_code;
`ifdef UART_FRM_STATS_EN
  assign good_cnt  = r_good_cnt;
  assign bad_cnt   = r_bad_cnt;
`endif

endmodule
